// File: rtl/instruction_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_dispatcher_pkg
// Brief    : Shared types for the ternary-matmul AFU instruction dispatcher:
//            instruction word, functional-unit codes, masks and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_dispatcher_pkg;

   localparam int NumInstructions    = 29;
   localparam int NumVectorRegisters = 8;
   localparam int NumFunctionalUnits = 4;

   typedef logic [$clog2(NumInstructions)-1:0]    pc_t;
   typedef logic [$clog2(NumVectorRegisters)-1:0] vreg_t;
   typedef logic [$clog2(NumFunctionalUnits)-1:0] fu_idx_t;
   typedef logic [NumFunctionalUnits-1:0]         fu_mask_t;
   typedef logic [NumVectorRegisters-1:0]         vreg_mask_t;

   // Codes 5..7 are undefined and flagged as illegal by the dispatcher.
   typedef enum logic [2:0] {
      NOP               = 3'd0,
      LOAD_STORE        = 3'd1,
      ROWWISE_OPERATION = 3'd2,
      TMATMUL           = 3'd3,
      RMS               = 3'd4
   } fu_t;

   typedef struct packed {
      fu_t        fu;
      logic [3:0] op;
      vreg_t      v_a;
      vreg_t      v_b;
      vreg_t      v_y;
   } instruction_t;

   // Functional-unit index of an issuable code (LOAD_STORE maps to 0).
   function automatic fu_idx_t fu2idx(input fu_t fu);
      return fu_idx_t'(fu - 3'd1);
   endfunction

   // True for codes that name a real functional unit.
   function automatic logic fu_is_unit(input fu_t fu);
      return (fu != NOP) && (fu <= RMS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_dispatcher_vreg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : vreg_scoreboard
// Brief    : Tracks which functional units are busy and which vector register
//            each one will write; reports source-operand hazards and the
//            per-register pending mask.
// Revision : 1.0 - initial release
// ============================================================================
module vreg_scoreboard
   import instruction_dispatcher_pkg::*;
#(
   parameter int NumFu = NumFunctionalUnits
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_i,
   input  logic [NumFu-1:0] issue_mask_i,
   input  vreg_t            issue_dest_i,
   input  logic [NumFu-1:0] done_i,
   input  vreg_t            src_a_i,
   input  vreg_t            src_b_i,
   output logic             hazard_o,
   output logic [NumFu-1:0] fu_busy_o,
   output vreg_mask_t       pending_o
);

   logic [NumFu-1:0] fu_busy_q;
   logic [NumFu-1:0] fu_busy_d;
   vreg_t            dest_q [NumFu];

   // Done pulses on idle units fall out naturally; a new issue always wins.
   always_comb fu_busy_d = (fu_busy_q & ~done_i) | (issue_i ? issue_mask_i : '0);

   // Busy flags and destination registers of outstanding instructions.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fu_busy_q <= '0;
         for (int i = 0; i < NumFu; i++) dest_q[i] <= '0;
      end else begin
         fu_busy_q <= fu_busy_d;
         for (int i = 0; i < NumFu; i++)
            if (issue_i && issue_mask_i[i]) dest_q[i] <= issue_dest_i;
      end
   end

   // One bit per vector register that a busy unit will still write.
   always_comb begin
      pending_o = '0;
      for (int i = 0; i < NumFu; i++)
         if (fu_busy_q[i]) pending_o[dest_q[i]] = 1'b1;
   end

   assign hazard_o  = pending_o[src_a_i] | pending_o[src_b_i];
   assign fu_busy_o = fu_busy_q;

endmodule
`default_nettype wire

// File: rtl/instruction_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : instruction_dispatcher
// Brief    : In-order fetch/decode/issue sequencer for the ternary-matmul AFU.
//            Issues each instruction to its functional unit over valid/ready
//            and pulses done once the program is issued and all units idle.
//            DISPATCH_SCOREBOARD_EN: when defined, register-hazard tracking
//            lets different units overlap; otherwise issue waits for all
//            units to be idle.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_dispatcher
   import instruction_dispatcher_pkg::*;
#(
   parameter int ProgramLength = NumInstructions,
   parameter int NumFu         = NumFunctionalUnits
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             illegal_o,
   output pc_t              imem_addr_o,
   input  instruction_t     imem_data_i,
   output instruction_t     instr_o,
   output logic [NumFu-1:0] fu_valid_o,
   input  logic [NumFu-1:0] fu_ready_i,
   input  logic [NumFu-1:0] fu_done_i
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   pc_t              pc_q, pc_d;
   instruction_t     instr_q, instr_d;
   logic             illegal_q, illegal_d;
   logic [NumFu-1:0] issue_mask;
   logic [NumFu-1:0] fu_busy;
   logic             can_issue;
   logic             issue_valid;
   logic             handshake;
   logic             retire;

   assign issue_mask = {{(NumFu-1){1'b0}}, 1'b1} << fu2idx(instr_q.fu);
   assign handshake  = issue_valid && |(fu_ready_i & issue_mask);

`ifdef DISPATCH_SCOREBOARD_EN
   logic       src_hazard;
   vreg_mask_t pending;

   vreg_scoreboard #(.NumFu(NumFu)) u_scoreboard (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .issue_i      (handshake),
      .issue_mask_i (issue_mask),
      .issue_dest_i (instr_q.v_y),
      .done_i       (fu_done_i),
      .src_a_i      (instr_q.v_a),
      .src_b_i      (instr_q.v_b),
      .hazard_o     (src_hazard),
      .fu_busy_o    (fu_busy),
      .pending_o    (pending)
   );

   // Sources are checked inside the scoreboard; the destination (WAW) here.
   assign can_issue = ~|(fu_busy & issue_mask) & ~src_hazard & ~pending[instr_q.v_y];
`else
   logic [NumFu-1:0] fu_busy_q;

   // Busy flags only; issue is fully serialised so no register tracking.
   always_ff @(posedge clk_i) begin
      if (rst_i) fu_busy_q <= '0;
      else       fu_busy_q <= (fu_busy_q & ~fu_done_i) | (handshake ? issue_mask : '0);
   end

   assign fu_busy   = fu_busy_q;
   assign can_issue = (fu_busy_q == '0);
`endif

   // Sequencer next-state logic: fetch, decode, issue, retire, drain.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      illegal_d   = illegal_q;
      issue_valid = 1'b0;
      retire      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               illegal_d = 1'b0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            instr_d = imem_data_i;
            if (imem_data_i.fu > RMS) illegal_d = 1'b1;
            if (fu_is_unit(imem_data_i.fu)) state_d = S_ISSUE;
            else                            retire  = 1'b1;
         end
         S_ISSUE: begin
            issue_valid = can_issue;
            retire      = handshake;
         end
         S_DRAIN: if (fu_busy == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (retire) begin
         if (pc_q == pc_t'(ProgramLength - 1)) begin
            state_d = S_DRAIN;
         end else begin
            pc_d    = pc_q + pc_t'(1);
            state_d = S_FETCH;
         end
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         instr_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         illegal_q <= illegal_d;
      end
   end

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign illegal_o   = illegal_q;
   assign imem_addr_o = pc_q;
   assign instr_o     = instr_q;
   assign fu_valid_o  = issue_valid ? issue_mask : '0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_dispatcher
// Brief    : Self-checking bench for instruction_dispatcher. Random programs
//            and random FU ready/latency behaviour are checked every cycle
//            against a timeline model of the dispatcher's issue rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_dispatcher;
   import instruction_dispatcher_pkg::*;

   localparam int N   = NumInstructions;
   localparam int NFU = NumFunctionalUnits;
   localparam int INF = 32'h7fff_ffff;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           start_i = 1'b0;
   logic           busy_o, done_o, illegal_o;
   pc_t            imem_addr_o;
   instruction_t   imem_data_i;
   instruction_t   instr_o;
   logic [NFU-1:0] fu_valid_o;
   logic [NFU-1:0] fu_ready_i = '0;
   logic [NFU-1:0] fu_done_i = '0;

   instruction_t prog [N];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_done = -1;

   // Model of the run as a timeline: which instruction, when it was fetched.
   bit    running = 0, draining = 0, illegal_m = 0;
   int    k = 0, t_fetch = 0, drain_from = 0;
   bit    out_m [NFU];
   int    donec [NFU];
   vreg_t dest_m [NFU];
   int    lat [NFU];

   always #5 clk_i = ~clk_i;

   // Synchronous-read instruction memory.
   always @(posedge clk_i)
      if (int'(imem_addr_o) < N) imem_data_i <= prog[int'(imem_addr_o)];
      else                       imem_data_i <= '0;

   instruction_dispatcher dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .illegal_o   (illegal_o),
      .imem_addr_o (imem_addr_o),
      .imem_data_i (imem_data_i),
      .instr_o     (instr_o),
      .fu_valid_o  (fu_valid_o),
      .fu_ready_i  (fu_ready_i),
      .fu_done_i   (fu_done_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit legal_fu(input fu_t f);
      return (int'(f) >= 1) && (int'(f) <= 4);
   endfunction

   // A unit whose done pulse came in cycle d accepts work from cycle d+1.
   function automatic bit fu_free(input int i, input int c);
      return !out_m[i] || (donec[i] < c);
   endfunction

   function automatic bit all_free(input int c);
      for (int i = 0; i < NFU; i++) if (!fu_free(i, c)) return 0;
      return 1;
   endfunction

   function automatic bit may_issue(input instruction_t ins, input int c);
`ifdef DISPATCH_SCOREBOARD_EN
      int t;
      t = int'(ins.fu) - 1;
      if (!fu_free(t, c)) return 0;
      for (int i = 0; i < NFU; i++)
         if (!fu_free(i, c) &&
             (dest_m[i] == ins.v_a || dest_m[i] == ins.v_b || dest_m[i] == ins.v_y))
            return 0;
      return 1;
`else
      return all_free(c);
`endif
   endfunction

   task automatic retire_m();
      if (k == N - 1) begin
         draining   = 1;
         drain_from = cyc + 2;
      end else begin
         k++;
         t_fetch = cyc + 1;
      end
   endtask

   task automatic reset_model();
      running = 0; draining = 0; illegal_m = 0;
      for (int i = 0; i < NFU; i++) begin
         out_m[i] = 0; donec[i] = INF; lat[i] = 0;
      end
   endtask

   // One clock cycle: check outputs, drive inputs, advance the model.
   task automatic step(input bit do_start, input bit do_rst);
      logic [NFU-1:0] exp_v, rdy, dn;
      bit in_issue, exp_done, hs;
      int fi;
      @(negedge clk_i);
      cyc++;
      exp_v = '0; in_issue = 0; fi = 0;
      if (running && !draining && cyc >= t_fetch + 2 && legal_fu(prog[k].fu)) begin
         in_issue = 1;
         fi = int'(prog[k].fu) - 1;
         if (may_issue(prog[k], cyc)) exp_v[fi] = 1'b1;
      end
      exp_done = running && draining && (cyc >= drain_from) && all_free(cyc - 1);
      check("fu_valid", 32'(fu_valid_o), 32'(exp_v));
      check("busy", 32'(busy_o), 32'(running));
      check("done", 32'(done_o), 32'(exp_done));
      check("illegal", 32'(illegal_o), 32'(illegal_m));
      if (in_issue) check("instr", 32'(instr_o), 32'(prog[k]));
      if (running && !draining && cyc == t_fetch) check("imem_addr", 32'(imem_addr_o), 32'(k));
      if (done_o === 1'b1) last_done = cyc;

      rdy = NFU'($urandom) | NFU'($urandom);
      dn  = '0;
      for (int i = 0; i < NFU; i++) begin
         if (out_m[i] && donec[i] == INF) begin
            if (lat[i] == 0) begin dn[i] = 1'b1; donec[i] = cyc; end
            else lat[i]--;
         end else if (!exp_v[i] && $urandom_range(15) == 0) begin
            dn[i] = 1'b1;
         end
      end
      hs = |(exp_v & rdy);
      start_i    = do_start;
      rst_i      = do_rst;
      fu_ready_i = rdy;
      fu_done_i  = dn;

      if (do_rst) begin
         reset_model();
      end else begin
         if (hs) begin
            out_m[fi]  = 1;
            donec[fi]  = INF;
            dest_m[fi] = prog[k].v_y;
            lat[fi]    = $urandom_range(5);
            retire_m();
         end else if (running && !draining && cyc == t_fetch + 1) begin
            if (int'(prog[k].fu) > 4) illegal_m = 1;
            if (!legal_fu(prog[k].fu)) retire_m();
         end
         if (exp_done) running = 0;
         if (do_start && !running) begin
            running = 1; draining = 0; illegal_m = 0; k = 0; t_fetch = cyc + 1;
         end
      end
   endtask

   task automatic run_program(output int done_lat);
      int s, n;
      last_done = -1;
      step(1, 0);
      s = cyc;
      n = 0;
      while (running && n < 3000) begin
         step(0, 0);
         n++;
      end
      if (running) begin
         check("run_timeout", 32'(running), 32'(0));
         step(0, 1);
      end
      step(0, 0);
      done_lat = last_done - s;
   endtask

   task automatic random_program();
      int r;
      for (int j = 0; j < N; j++) begin
         r = $urandom_range(15);
         if (r < 3)       prog[j].fu = NOP;
         else if (r == 3) prog[j].fu = fu_t'(3'($urandom_range(7, 5)));
         else             prog[j].fu = fu_t'(3'($urandom_range(4, 1)));
         prog[j].op  = 4'($urandom);
         prog[j].v_a = vreg_t'($urandom_range(5));
         prog[j].v_b = vreg_t'($urandom_range(5));
         prog[j].v_y = vreg_t'($urandom_range(7));
      end
   endtask

   initial begin
      int dl;
      int n;
      reset_model();
      for (int j = 0; j < N; j++) prog[j] = '0;
      repeat (3) @(negedge clk_i);
      check("rst_valid", 32'(fu_valid_o), 32'(0));
      check("rst_busy", 32'(busy_o), 32'(0));
      check("rst_done", 32'(done_o), 32'(0));
      check("rst_illegal", 32'(illegal_o), 32'(0));
      check("rst_addr", 32'(imem_addr_o), 32'(0));
      check("rst_instr", 32'(instr_o), 32'(0));
      rst_i = 1'b0;

      // All-NOP program: two cycles per word, then drain and done.
      run_program(dl);
      check("nop_done_latency", 32'(dl), 32'(1 + 2 * N + 1));

      // Hazard chain, non-overlapping unit, illegal code.
      for (int j = 0; j < N; j++) prog[j] = '0;
      prog[0] = '{fu: TMATMUL,           op: 4'd0, v_a: 3'd0, v_b: 3'd1, v_y: 3'd2};
      prog[1] = '{fu: ROWWISE_OPERATION, op: 4'd1, v_a: 3'd2, v_b: 3'd3, v_y: 3'd4};
      prog[2] = '{fu: RMS,               op: 4'd0, v_a: 3'd5, v_b: 3'd5, v_y: 3'd6};
      prog[3] = '{fu: fu_t'(3'd6),       op: 4'd0, v_a: 3'd0, v_b: 3'd0, v_y: 3'd0};
      prog[4] = '{fu: LOAD_STORE,        op: 4'd2, v_a: 3'd7, v_b: 3'd7, v_y: 3'd3};
      run_program(dl);

      // Randomised programs.
      for (int r = 0; r < 6; r++) begin
         random_program();
         run_program(dl);
      end

      // Reset in the middle of an issue, then a clean restart from pc 0.
      random_program();
      prog[0] = '{fu: TMATMUL, op: 4'd0, v_a: 3'd0, v_b: 3'd1, v_y: 3'd2};
      step(1, 0);
      n = 0;
      while (fu_valid_o == '0 && n < 50) begin
         step(0, 0);
         n++;
      end
      check("mid_issue_reached", 32'(fu_valid_o != '0), 32'(1));
      step(0, 1);
      step(0, 0);
      check("mid_rst_instr", 32'(instr_o), 32'(0));
      check("mid_rst_addr", 32'(imem_addr_o), 32'(0));
      run_program(dl);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
